// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: decodes the instruction opcode into a one-hot ALU op
// and holds it, stretching MUL over MUL_LAT cycles, with valid/ready, stall and flush.
module alu_ctrl_pipe #(
  parameter int INSTR_W = 16,
  parameter int MUL_LAT = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] Inp,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               stall,
  input  logic               flush,
  output logic [7:0]         Out,
  output logic               out_valid,
  output logic               illegal,
  output logic               busy
);

  // state  | meaning
  // IDLE   | nothing presented to the ALU, out_valid=0
  // ACTIVE | op on Out, cnt==0, a new op may be accepted
  // MULTI  | MUL still occupying the ALU, cnt>0
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_MULTI} state_t;

  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 1);
  localparam bit MUL_MULTI = (MUL_LAT > 1);

  state_t          r_state, w_nxt_state;
  logic [7:0]      r_out, w_nxt_out;
  logic            r_illegal, w_nxt_illegal;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;

  logic [4:0]      w_op;
  logic [7:0]      w_dec;
  logic            w_is_mul;
  logic            w_is_ill;
  logic            w_accept;

  assign w_op     = Inp[INSTR_W-1 -: 5];
  assign w_is_mul = (w_op == 5'b10111);
  assign w_is_ill = (w_op == 5'b11111);

  generate
    if (INSTR_W > 5) begin : g_unused
      logic w_unused_bits;
      assign w_unused_bits = ^Inp[INSTR_W-6:0];
    end
  endgenerate

  always_comb begin
    w_dec = 8'h01;
    casez (w_op)
      5'b1000?: w_dec = 8'h02;
      5'b10011: w_dec = 8'h04;
      5'b10010: w_dec = 8'h08;
      5'b10110: w_dec = 8'h10;
      5'b10101: w_dec = 8'h20;
      5'b10100: w_dec = 8'h40;
      5'b10111: w_dec = 8'h80;
      5'b11111: w_dec = 8'h00;
      default:  w_dec = 8'h01;
    endcase
  end

  assign in_ready  = !stall && !flush && !rst && (r_cnt == '0);
  assign w_accept  = in_valid && in_ready;
  assign Out       = r_out;
  assign illegal   = r_illegal;
  assign out_valid = (r_state != S_IDLE);
  assign busy      = (r_cnt != '0);

  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_out     = r_out;
    w_nxt_illegal = r_illegal;
    w_nxt_cnt     = r_cnt;
    if (flush) begin
      w_nxt_state   = S_IDLE;
      w_nxt_out     = 8'h00;
      w_nxt_illegal = 1'b0;
      w_nxt_cnt     = '0;
    end else if (stall) begin
      w_nxt_state = r_state;
    end else if (w_accept) begin
      w_nxt_out     = w_dec;
      w_nxt_illegal = w_is_ill;
      if (w_is_mul && MUL_MULTI) begin
        w_nxt_state = S_MULTI;
        w_nxt_cnt   = MUL_LOAD;
      end else begin
        w_nxt_state = S_ACTIVE;
        w_nxt_cnt   = '0;
      end
    end else begin
      case (r_state)
        S_ACTIVE: begin
          w_nxt_state   = S_IDLE;
          w_nxt_out     = 8'h00;
          w_nxt_illegal = 1'b0;
        end
        S_MULTI: begin
          // Out/illegal stay put; last MUL cycle is ACTIVE so the next op can issue
          w_nxt_cnt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) w_nxt_state = S_ACTIVE;
        end
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_out     <= 8'h00;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_nxt_state;
      r_out     <= w_nxt_out;
      r_illegal <= w_nxt_illegal;
      r_cnt     <= w_nxt_cnt;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: opcode sweep, MUL timing, stall, flush, reset,
// plus a MUL_LAT=1 / INSTR_W=32 instance.
module tb_alu_ctrl_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, stall, flush;
  logic [15:0] Inp;
  logic        in_ready, out_valid, illegal, busy;
  logic [7:0]  Out;

  logic        b_rst, b_in_valid, b_stall, b_flush;
  logic [31:0] b_Inp;
  logic        b_in_ready, b_out_valid, b_illegal, b_busy;
  logic [7:0]  b_Out;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] dec_tbl [32];

  alu_ctrl_pipe #(.INSTR_W(16), .MUL_LAT(3)) u_dut (
    .clk(clk), .rst(rst), .Inp(Inp), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .Out(Out), .out_valid(out_valid),
    .illegal(illegal), .busy(busy)
  );

  alu_ctrl_pipe #(.INSTR_W(32), .MUL_LAT(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .Inp(b_Inp), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .stall(b_stall), .flush(b_flush), .Out(b_Out), .out_valid(b_out_valid),
    .illegal(b_illegal), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op);
    return {op, 11'h2A5};
  endfunction

  initial begin
    dec_tbl = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01,
                8'h02, 8'h02, 8'h08, 8'h04, 8'h40, 8'h20, 8'h10, 8'h80,
                8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};

    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b1; Inp = mk(5'b10111);
    b_rst = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_Inp = '0;
    tick(); tick();
    chk("rst_out",      Out,       8'h00);
    chk("rst_valid",    out_valid, 8'h00);
    chk("rst_illegal",  illegal,   8'h00);
    chk("rst_busy",     busy,      8'h00);
    chk("rst_in_ready", in_ready,  8'h00);

    // every opcode back-to-back
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      Inp = mk(5'(i)); in_valid = 1'b1;
      #1;
      chk("sweep_ready", in_ready, 8'h01);
      tick();
      chk($sformatf("sweep_out_%0d", i), Out, dec_tbl[i]);
      chk("sweep_valid", out_valid, 8'h01);
      chk($sformatf("sweep_ill_%0d", i), illegal, (i == 31) ? 8'h01 : 8'h00);
      if (i == 23) begin
        Inp = mk(5'd24);
        #1;
        chk("sweep_mul_ready1", in_ready, 8'h00);
        chk("sweep_mul_busy1",  busy,     8'h01);
        tick();
        chk("sweep_mul_out2",   Out,      8'h80);
        chk("sweep_mul_busy2",  busy,     8'h01);
        tick();
        chk("sweep_mul_out3",   Out,      8'h80);
        chk("sweep_mul_busy3",  busy,     8'h00);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("idle_valid",   out_valid, 8'h00);
    chk("idle_out",     Out,       8'h00);
    chk("idle_illegal", illegal,   8'h00);

    // MUL followed by a continuously valid 10011
    Inp = mk(5'b10111); in_valid = 1'b1;
    tick();
    Inp = mk(5'b10011);
    #1;
    chk("mul_t1_out",   Out,      8'h80);
    chk("mul_t1_busy",  busy,     8'h01);
    chk("mul_t1_ready", in_ready, 8'h00);
    tick();
    chk("mul_t2_out",   Out,      8'h80);
    chk("mul_t2_busy",  busy,     8'h01);
    chk("mul_t2_ready", in_ready, 8'h00);
    tick();
    chk("mul_t3_out",   Out,      8'h80);
    chk("mul_t3_busy",  busy,     8'h00);
    chk("mul_t3_ready", in_ready, 8'h01);
    tick();
    chk("mul_t4_out",   Out,      8'h04);
    in_valid = 1'b0;
    tick();
    chk("mul_idle", out_valid, 8'h00);

    // stall for two cycles starting at T+2
    Inp = mk(5'b10111); in_valid = 1'b1;
    tick();
    Inp = mk(5'b10010);
    tick();
    stall = 1'b1;
    #1;
    chk("stall_ready", in_ready, 8'h00);
    tick();
    chk("stall_t3_out",  Out,  8'h80);
    chk("stall_t3_busy", busy, 8'h01);
    tick();
    chk("stall_t4_out",  Out,  8'h80);
    chk("stall_t4_busy", busy, 8'h01);
    stall = 1'b0;
    tick();
    chk("stall_t5_out",   Out,      8'h80);
    chk("stall_t5_busy",  busy,     8'h00);
    chk("stall_t5_ready", in_ready, 8'h01);
    tick();
    chk("stall_t6_out", Out, 8'h08);
    in_valid = 1'b0;
    tick();

    // flush at T+2 with a valid instruction present
    Inp = mk(5'b10111); in_valid = 1'b1;
    tick();
    tick();
    Inp = mk(5'b10000); flush = 1'b1;
    #1;
    chk("flush_ready", in_ready, 8'h00);
    tick();
    chk("flush_valid", out_valid, 8'h00);
    chk("flush_busy",  busy,      8'h00);
    chk("flush_out",   Out,       8'h00);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_ready_after", in_ready, 8'h01);
    tick();
    chk("flush_dropped", out_valid, 8'h00);

    // rst with stall mid-MUL
    Inp = mk(5'b11111); in_valid = 1'b1;
    tick();
    Inp = mk(5'b10111);
    tick();
    tick();
    chk("rstmul_busy_pre", busy, 8'h01);
    rst = 1'b1; stall = 1'b1;
    tick();
    chk("rstmul_out",     Out,       8'h00);
    chk("rstmul_valid",   out_valid, 8'h00);
    chk("rstmul_illegal", illegal,   8'h00);
    chk("rstmul_busy",    busy,      8'h00);
    chk("rstmul_ready",   in_ready,  8'h00);
    rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();

    // MUL_LAT=1, INSTR_W=32 instance
    b_rst = 1'b0;
    b_Inp = {5'b10111, 27'h7FF_FFFF}; b_in_valid = 1'b1;
    #1;
    chk("b_ready0", b_in_ready, 8'h01);
    tick();
    chk("b_mul_out",   b_Out,       8'h80);
    chk("b_mul_valid", b_out_valid, 8'h01);
    chk("b_mul_busy",  b_busy,      8'h00);
    chk("b_mul_ill",   b_illegal,   8'h00);
    b_Inp = {5'b10011, 27'h0};
    #1;
    chk("b_ready1", b_in_ready, 8'h01);
    tick();
    chk("b_next_out",  b_Out,  8'h04);
    chk("b_next_busy", b_busy, 8'h00);
    b_Inp = {5'b11111, 27'h0};
    tick();
    chk("b_ill_out", b_Out,     8'h00);
    chk("b_ill",     b_illegal, 8'h01);
    b_in_valid = 1'b0;
    tick();
    chk("b_idle", b_out_valid, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
